// File: rtl/ether_pkg.sv
// Purpose: shared constants, state encoding and frame-check helper for the ether_on serial
//          command frame receiver.
// Contents: frame length, required header/separator/trailer values, field bit offsets,
//           error codes, receiver FSM state type, frame_check() priority checker.
package ether_pkg;

  localparam int unsigned SEQ_LEN     = 58;
  localparam int unsigned TIMEOUT_CYC = 4096;

  localparam logic [16:0] HDR_VAL = 17'h03000;
  localparam logic [1:0]  SEP_VAL = 2'b11;
  localparam logic [4:0]  TRL_VAL = 5'b11000;

  // Frame bit offsets, frame bit 57 is first on the line.
  localparam int unsigned HDR_MSB  = 57;
  localparam int unsigned HDR_LSB  = 41;
  localparam int unsigned SEP1_MSB = 40;
  localparam int unsigned SEP1_LSB = 39;
  localparam int unsigned FA_MSB   = 38;
  localparam int unsigned FA_LSB   = 23;
  localparam int unsigned SEP2_MSB = 22;
  localparam int unsigned SEP2_LSB = 21;
  localparam int unsigned FB_MSB   = 20;
  localparam int unsigned FB_LSB   = 5;
  localparam int unsigned TRL_MSB  = 4;
  localparam int unsigned TRL_LSB  = 0;

  localparam logic [2:0] ERR_NONE = 3'd0;
  localparam logic [2:0] ERR_HDR  = 3'd1;
  localparam logic [2:0] ERR_SEP  = 3'd2;
  localparam logic [2:0] ERR_TRL  = 3'd3;
  localparam logic [2:0] ERR_TMO  = 3'd4;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StArmed = 2'd1,
    StShift = 2'd2,
    StCheck = 2'd3
  } rx_state_e;

  // Returns the first failing check in priority order, or ERR_NONE for a good frame.
  function automatic logic [2:0] frame_check(input logic [SEQ_LEN-1:0] frame);
    if (frame[HDR_MSB:HDR_LSB] != HDR_VAL) begin
      return ERR_HDR;
    end
    if ((frame[SEP1_MSB:SEP1_LSB] != SEP_VAL) || (frame[SEP2_MSB:SEP2_LSB] != SEP_VAL)) begin
      return ERR_SEP;
    end
    if (frame[TRL_MSB:TRL_LSB] != TRL_VAL) begin
      return ERR_TRL;
    end
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/ether_sync_edge.sv
// Purpose: bring an asynchronous level into the clk_in domain through two flops and flag
//          its 0->1 transitions.
// Ports: clk_in, reset_in (async, active-low), async_in (raw level),
//        rise_out (one-cycle pulse on each synchronized rising edge).
module ether_sync_edge (
  input  logic clk_in,
  input  logic reset_in,
  input  logic async_in,
  output logic rise_out
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= async_in;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign rise_out = r_sync & ~r_prev;

endmodule

// File: rtl/ether_frame_rx.sv
// Purpose: receive 58-bit serial command frames from the ether_on generator, check framing
//          and extract the two 16-bit payload fields.
// Ports: clk_in/reset_in (async, active-low); sclk_in/sdata_in serial line (async);
//        rx_enable_in abort/hold; frame_valid_out/frame_err_out one-cycle pulses;
//        field_a_out/field_b_out payload; err_code_out last error; busy_out in SHIFT/CHECK;
//        frame_cnt_out good-frame count.
module ether_frame_rx
  import ether_pkg::*;
(
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        sclk_in,
  input  logic        sdata_in,
  input  logic        rx_enable_in,
  output logic        frame_valid_out,
  output logic [15:0] field_a_out,
  output logic [15:0] field_b_out,
  output logic        frame_err_out,
  output logic [2:0]  err_code_out,
  output logic        busy_out,
  output logic [15:0] frame_cnt_out
);

  localparam logic [12:0] TMO_LAST = 13'(TIMEOUT_CYC - 1);
  localparam logic [5:0]  LAST_BIT = 6'(SEQ_LEN - 1);

  logic w_sample;
  logic r_sd_meta;
  logic r_sd_sync;

  rx_state_e          r_state, w_state_d;
  logic [SEQ_LEN-1:0] r_shreg, w_shreg_d;
  logic [5:0]         r_bit_cnt, w_bit_cnt_d;
  logic [12:0]        r_tmo, w_tmo_d;
  logic               r_valid, w_valid_d;
  logic               r_err, w_err_d;
  logic [2:0]         r_code, w_code_d;
  logic [15:0]        r_fa, w_fa_d;
  logic [15:0]        r_fb, w_fb_d;
  logic [15:0]        r_cnt, w_cnt_d;
  logic [2:0]         w_chk;

  ether_sync_edge u_sclk_sync (
    .clk_in   (clk_in),
    .reset_in (reset_in),
    .async_in (sclk_in),
    .rise_out (w_sample)
  );

  // Same two-flop depth as the sclk path, so data lines up with the sample event.
  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_sd_meta <= 1'b0;
      r_sd_sync <= 1'b0;
    end else begin
      r_sd_meta <= sdata_in;
      r_sd_sync <= r_sd_meta;
    end
  end

  assign w_chk = frame_check(r_shreg);

  always_comb begin
    w_state_d   = r_state;
    w_shreg_d   = r_shreg;
    w_bit_cnt_d = r_bit_cnt;
    w_tmo_d     = r_tmo;
    w_valid_d   = 1'b0;
    w_err_d     = 1'b0;
    w_code_d    = r_code;
    w_fa_d      = r_fa;
    w_fb_d      = r_fb;
    w_cnt_d     = r_cnt;
    if (!rx_enable_in) begin
      // Abort overrides sample and timeout events.
      w_state_d   = StIdle;
      w_shreg_d   = '0;
      w_bit_cnt_d = '0;
      w_tmo_d     = '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_sample && r_sd_sync) w_state_d = StArmed;
        end
        StArmed: begin
          // The start bit is frame bit 57 (header MSB, always 0).
          if (w_sample && !r_sd_sync) begin
            w_state_d   = StShift;
            w_shreg_d   = '0;
            w_bit_cnt_d = 6'd1;
            w_tmo_d     = '0;
          end
        end
        StShift: begin
          if (r_tmo == TMO_LAST) begin
            // Timeout wins over a coincident sample.
            w_state_d   = StIdle;
            w_err_d     = 1'b1;
            w_code_d    = ERR_TMO;
            w_shreg_d   = '0;
            w_bit_cnt_d = '0;
            w_tmo_d     = '0;
          end else if (w_sample) begin
            w_shreg_d   = {r_shreg[SEQ_LEN-2:0], r_sd_sync};
            w_bit_cnt_d = r_bit_cnt + 6'd1;
            w_tmo_d     = '0;
            if (r_bit_cnt == LAST_BIT) w_state_d = StCheck;
          end else begin
            w_tmo_d = r_tmo + 13'd1;
          end
        end
        StCheck: begin
          w_state_d   = StIdle;
          w_bit_cnt_d = '0;
          w_tmo_d     = '0;
          if (w_chk == ERR_NONE) begin
            w_valid_d = 1'b1;
            w_fa_d    = r_shreg[FA_MSB:FA_LSB];
            w_fb_d    = r_shreg[FB_MSB:FB_LSB];
            w_cnt_d   = r_cnt + 16'd1;
          end else begin
            w_err_d  = 1'b1;
            w_code_d = w_chk;
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      r_state   <= StIdle;
      r_shreg   <= '0;
      r_bit_cnt <= '0;
      r_tmo     <= '0;
      r_valid   <= 1'b0;
      r_err     <= 1'b0;
      r_code    <= ERR_NONE;
      r_fa      <= '0;
      r_fb      <= '0;
      r_cnt     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_shreg   <= w_shreg_d;
      r_bit_cnt <= w_bit_cnt_d;
      r_tmo     <= w_tmo_d;
      r_valid   <= w_valid_d;
      r_err     <= w_err_d;
      r_code    <= w_code_d;
      r_fa      <= w_fa_d;
      r_fb      <= w_fb_d;
      r_cnt     <= w_cnt_d;
    end
  end

  assign frame_valid_out = r_valid;
  assign frame_err_out   = r_err;
  assign err_code_out    = r_code;
  assign field_a_out     = r_fa;
  assign field_b_out     = r_fb;
  assign frame_cnt_out   = r_cnt;
  assign busy_out        = (r_state == StShift) || (r_state == StCheck);

endmodule

// File: tb/tb_ether_frame_rx.sv
// Directed bench for ether_frame_rx: drives serial frames bit by bit and checks flags,
// fields, error codes and the good-frame counter against hand-computed values.
module tb_ether_frame_rx;

  logic        clk_in = 1'b0;
  logic        reset_in = 1'b0;
  logic        sclk_in = 1'b0;
  logic        sdata_in = 1'b1;
  logic        rx_enable_in = 1'b1;
  logic        frame_valid_out;
  logic [15:0] field_a_out;
  logic [15:0] field_b_out;
  logic        frame_err_out;
  logic [2:0]  err_code_out;
  logic        busy_out;
  logic [15:0] frame_cnt_out;

  int n_pass = 0;
  int n_total = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  ether_frame_rx dut (
    .clk_in          (clk_in),
    .reset_in        (reset_in),
    .sclk_in         (sclk_in),
    .sdata_in        (sdata_in),
    .rx_enable_in    (rx_enable_in),
    .frame_valid_out (frame_valid_out),
    .field_a_out     (field_a_out),
    .field_b_out     (field_b_out),
    .frame_err_out   (frame_err_out),
    .err_code_out    (err_code_out),
    .busy_out        (busy_out),
    .frame_cnt_out   (frame_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  always @(negedge clk_in) begin
    if (frame_valid_out) valid_cnt++;
    if (frame_err_out) err_cnt++;
    if (frame_valid_out && frame_err_out) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [57:0] mk(input logic [15:0] a, input logic [15:0] b);
    return {17'h03000, 2'b11, a, 2'b11, b, 5'b11000};
  endfunction

  task automatic send_bit(input logic b, input int half);
    sdata_in = b;
    repeat (half) @(negedge clk_in);
    sclk_in = 1'b1;
    repeat (half) @(negedge clk_in);
    sclk_in = 1'b0;
  endtask

  // Two idle-high bits, then the first nbits of the frame, MSB first.
  task automatic send_bits(input logic [57:0] f, input int nbits, input int half);
    send_bit(1'b1, half);
    send_bit(1'b1, half);
    for (int i = 57; i > 57 - nbits; i--) send_bit(f[i], half);
  endtask

  task automatic send_frame(input logic [57:0] f, input int half);
    send_bits(f, 58, half);
    sdata_in = 1'b1;
    repeat (8) @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset_in = 1'b0;
    sclk_in  = 1'b0;
    sdata_in = 1'b1;
    repeat (3) @(negedge clk_in);
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
  endtask

  initial begin
    logic [57:0] f;
    int v0, e0, k;
    bit seen;

    repeat (3) @(negedge clk_in);
    check("rst_valid", frame_valid_out, 0);
    check("rst_err", frame_err_out, 0);
    check("rst_code", err_code_out, 0);
    check("rst_busy", busy_out, 0);
    check("rst_fa", field_a_out, 0);
    check("rst_cnt", frame_cnt_out, 0);
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);

    // 1: good frame at a 400-cycle sclk period
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(mk(16'h000F, 16'h0000), 200);
    check("t1_valid", valid_cnt - v0, 1);
    check("t1_err", err_cnt - e0, 0);
    check("t1_fa", field_a_out, 16'h000F);
    check("t1_fb", field_b_out, 16'h0000);
    check("t1_cnt", frame_cnt_out, 1);

    // 2: two back-to-back frames from a fresh reset
    do_reset();
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(mk(16'h0003, 16'hFFFC), 8);
    check("t2a_fa", field_a_out, 16'h0003);
    check("t2a_fb", field_b_out, 16'hFFFC);
    send_frame(mk(16'h0003, 16'hFFC3), 8);
    check("t2b_fa", field_a_out, 16'h0003);
    check("t2b_fb", field_b_out, 16'hFFC3);
    check("t2_valid", valid_cnt - v0, 2);
    check("t2_err", err_cnt - e0, 0);
    check("t2_cnt", frame_cnt_out, 2);

    // 3: bad trailer
    v0 = valid_cnt; e0 = err_cnt;
    f = mk(16'hAAAA, 16'h5555);
    f[4:0] = 5'b11001;
    send_frame(f, 8);
    check("t3_err", err_cnt - e0, 1);
    check("t3_valid", valid_cnt - v0, 0);
    check("t3_code", err_code_out, 3);
    check("t3_fa", field_a_out, 16'h0003);
    check("t3_fb", field_b_out, 16'hFFC3);
    check("t3_cnt", frame_cnt_out, 2);

    // 4: header and separator both bad, header wins
    e0 = err_cnt;
    f = mk(16'h1234, 16'h5678);
    f[55] = ~f[55];
    f[40] = ~f[40];
    send_frame(f, 8);
    check("t4_err", err_cnt - e0, 1);
    check("t4_code", err_code_out, 1);
    check("t4_cnt", frame_cnt_out, 2);

    // 5: sclk stops after 20 bits; timeout measured from the last sclk rise
    e0 = err_cnt;
    f = mk(16'h0F0F, 16'hF0F0);
    send_bits(f, 19, 8);
    sdata_in = f[57-19];
    repeat (8) @(negedge clk_in);
    sclk_in = 1'b1;
    k = 0;
    seen = 1'b0;
    while (!seen && k < 4300) begin
      @(negedge clk_in);
      k++;
      if (k == 100) check("t5_busy_mid", busy_out, 1);
      if (frame_err_out) seen = 1'b1;
    end
    check("t5_seen", seen, 1);
    check("t5_lat_window", (k >= 4096 && k <= 4101), 1);
    check("t5_code", err_code_out, 4);
    @(negedge clk_in);
    check("t5_busy_after", busy_out, 0);
    sclk_in = 1'b0;
    repeat (4) @(negedge clk_in);
    v0 = valid_cnt;
    send_frame(mk(16'hBEEF, 16'hCAFE), 8);
    check("t5_next_valid", valid_cnt - v0, 1);
    check("t5_next_fa", field_a_out, 16'hBEEF);
    check("t5_next_fb", field_b_out, 16'hCAFE);
    check("t5_cnt", frame_cnt_out, 3);

    // 6: reset mid-frame, then a clean frame
    send_bits(mk(16'h1111, 16'h2222), 30, 8);
    reset_in = 1'b0;
    @(negedge clk_in);
    check("t6_rst_cnt", frame_cnt_out, 0);
    check("t6_rst_fa", field_a_out, 0);
    check("t6_rst_fb", field_b_out, 0);
    check("t6_rst_code", err_code_out, 0);
    check("t6_rst_busy", busy_out, 0);
    sclk_in = 1'b0;
    sdata_in = 1'b1;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b1;
    repeat (3) @(negedge clk_in);
    v0 = valid_cnt; e0 = err_cnt;
    send_frame(mk(16'h1357, 16'h2468), 8);
    check("t6_valid", valid_cnt - v0, 1);
    check("t6_err", err_cnt - e0, 0);
    check("t6_fa", field_a_out, 16'h1357);
    check("t6_cnt", frame_cnt_out, 1);

    // 7: rx_enable low at bit 40 aborts the frame silently
    v0 = valid_cnt; e0 = err_cnt;
    send_bits(mk(16'h7777, 16'h8888), 40, 8);
    rx_enable_in = 1'b0;
    repeat (2) @(negedge clk_in);
    check("t7_busy_abort", busy_out, 0);
    repeat (8) @(negedge clk_in);
    rx_enable_in = 1'b1;
    repeat (4) @(negedge clk_in);
    check("t7_no_valid", valid_cnt - v0, 0);
    check("t7_no_err", err_cnt - e0, 0);
    check("t7_cnt_held", frame_cnt_out, 1);
    check("t7_fa_held", field_a_out, 16'h1357);
    send_frame(mk(16'h4242, 16'h2424), 8);
    check("t7_next_valid", valid_cnt - v0, 1);
    check("t7_next_fb", field_b_out, 16'h2424);
    check("t7_cnt", frame_cnt_out, 2);
    check("t7_code_held", err_code_out, 0);

    check("never_both", both_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
